// File: rtl/axis_pkg.sv
// Shared definitions for the AXIS sample-packing stages.
// Holds default stream geometry, the run/idle state type, and a helper that
// turns a count of valid samples into a low-aligned tkeep byte mask.
package axis_pkg;

  localparam int unsigned DefDataWidth   = 256;
  localparam int unsigned DefKeepWidth   = DefDataWidth / 8;
  localparam int unsigned DefDepth       = 400;
  localparam int unsigned DefSampleWidth = 16;
  localparam int unsigned DefSpb         = DefDataWidth / DefSampleWidth;

  // Widest tkeep the mask helper can describe; callers slice it down.
  localparam int unsigned KeepMaskWidth  = 64;

  typedef enum logic {
    StIdle,
    StRun
  } run_state_e;

  // Lower (n_samples * sample_bytes) bytes set, remaining bytes clear.
  function automatic logic [KeepMaskWidth-1:0] keep_mask(input int unsigned n_samples,
                                                         input int unsigned sample_bytes);
    int unsigned n_bytes;
    n_bytes = n_samples * sample_bytes;
    if (n_bytes >= KeepMaskWidth) begin
      return '1;
    end
    return (KeepMaskWidth'(1) << n_bytes) - KeepMaskWidth'(1);
  endfunction

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry AXIS output FIFO with a dual push port.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_a, data_a   first push of the cycle
//   push_b, data_b   second push of the cycle, ordered after push_a
//   valid, data      head entry (registered), ready pops it
//   full, empty      occupancy flags
//   drop             a push found no room this cycle and was discarded
// A pop and push may share a cycle, even when full: the pop frees room first.
module axis_skid_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_a,
  input  logic [Width-1:0] data_a,
  input  logic             push_b,
  input  logic [Width-1:0] data_b,
  output logic             valid,
  output logic [Width-1:0] data,
  input  logic             ready,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  logic [Width-1:0] slot0_q, slot0_d;
  logic [Width-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;

  assign valid = (count_q != 2'd0);
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign data  = slot0_q;

  // Pop first, then append pushes in order; count_d tracks running occupancy.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    drop    = 1'b0;
    if (valid && ready) begin
      slot0_d = slot1_q;
      count_d = count_q - 2'd1;
    end
    if (push_a) begin
      if (count_d == 2'd0) begin
        slot0_d = data_a;
        count_d = 2'd1;
      end else if (count_d == 2'd1) begin
        slot1_d = data_a;
        count_d = 2'd2;
      end else begin
        drop = 1'b1;
      end
    end
    if (push_b) begin
      if (count_d == 2'd0) begin
        slot0_d = data_b;
        count_d = 2'd1;
      end else if (count_d == 2'd1) begin
        slot1_d = data_b;
        count_d = 2'd2;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/axis_sample_packer.sv
// Packs a non-backpressurable stream of samples into AXIS beats and frames
// them into DMA packets of AXIS_DATA_DEPTH beats.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   enable                          acquisition gate; falling edge flushes
//   sample_data, sample_valid       sample strobe, no backpressure
//   AXIS_sample_packer_AXIS_*       AXI-Stream master towards the DMA
//   overflow                        sticky, a beat was dropped (cleared on run start)
//   packet_count                    packets pushed with tlast, wraps
// A completed beat that is not the last of its packet waits in a staging
// register until the next sample or a flush decides its tlast.
module axis_sample_packer
  import axis_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = DefDataWidth,
  parameter int unsigned AXIS_DATA_KEEP  = DefKeepWidth,
  parameter int unsigned AXIS_DATA_DEPTH = DefDepth,
  parameter int unsigned SAMPLE_WIDTH    = DefSampleWidth
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [SAMPLE_WIDTH-1:0]    sample_data,
  input  logic                       sample_valid,
  output logic [AXIS_DATA_WIDTH-1:0] AXIS_sample_packer_AXIS_tdata,
  output logic [AXIS_DATA_KEEP-1:0]  AXIS_sample_packer_AXIS_tkeep,
  output logic                       AXIS_sample_packer_AXIS_tlast,
  output logic                       AXIS_sample_packer_AXIS_tvalid,
  input  logic                       AXIS_sample_packer_AXIS_tready,
  output logic                       overflow,
  output logic [31:0]                packet_count
);

  localparam int unsigned Spb         = AXIS_DATA_WIDTH / SAMPLE_WIDTH;
  localparam int unsigned SampleBytes = SAMPLE_WIDTH / 8;
  localparam int unsigned CntW        = (Spb > 1) ? $clog2(Spb) : 1;
  localparam int unsigned BeatW       = $clog2(AXIS_DATA_DEPTH);
  localparam int unsigned LaneW       = $clog2(AXIS_DATA_WIDTH);
  localparam int unsigned EntryW      = AXIS_DATA_WIDTH + AXIS_DATA_KEEP + 1;

  localparam logic [CntW-1:0]           LastLane = CntW'(Spb - 1);
  localparam logic [BeatW-1:0]          LastBeat = BeatW'(AXIS_DATA_DEPTH - 1);
  localparam logic [AXIS_DATA_KEEP-1:0] FullKeep = '1;

  run_state_e state_q, state_d;
  logic       rise, fall, accept;

  logic [CntW-1:0]            samp_cnt_q, samp_cnt_d, cnt_eff;
  logic [BeatW-1:0]           beat_cnt_q, beat_cnt_d, beat_eff;
  logic [AXIS_DATA_WIDTH-1:0] accum_q, accum_d, accum_new;
  logic                       stage_valid_q, stage_valid_d;
  logic [AXIS_DATA_WIDTH-1:0] stage_q, stage_d;
  logic                       overflow_q, overflow_d;
  logic [31:0]                pkt_cnt_q, pkt_cnt_d;
  logic [LaneW-1:0]           lane_base;

  logic [KeepMaskWidth-1:0]   keep_wide;
  logic [AXIS_DATA_KEEP-1:0]  partial_keep;

  logic              push_a, push_b, fifo_drop;
  logic [EntryW-1:0] entry_a, entry_b, fifo_head;
  logic              fifo_full, fifo_empty;
  logic              unused_flags;

  // Run/idle tracker; the registered state doubles as the delayed enable.
  always_comb begin
    state_d = enable ? StRun : StIdle;
    rise    = enable && (state_q == StIdle);
    fall    = !enable && (state_q == StRun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign accept = enable && sample_valid;

  // A run start restarts framing even if the sample of that cycle is accepted.
  assign cnt_eff   = rise ? '0 : samp_cnt_q;
  assign beat_eff  = rise ? '0 : beat_cnt_q;
  assign lane_base = LaneW'(32'(cnt_eff) * SAMPLE_WIDTH);

  always_comb begin
    accum_new = accum_q;
    accum_new[lane_base +: SAMPLE_WIDTH] = sample_data;
  end

  assign keep_wide    = keep_mask(32'(samp_cnt_q), SampleBytes);
  assign partial_keep = keep_wide[AXIS_DATA_KEEP-1:0];

  always_comb begin
    samp_cnt_d    = cnt_eff;
    beat_cnt_d    = beat_eff;
    accum_d       = accum_q;
    stage_valid_d = stage_valid_q;
    stage_d       = stage_q;
    pkt_cnt_d     = pkt_cnt_q;
    push_a        = 1'b0;
    push_b        = 1'b0;
    entry_a       = '0;
    entry_b       = '0;
    if (fall) begin
      if (samp_cnt_q != '0) begin
        if (stage_valid_q) begin
          push_a  = 1'b1;
          entry_a = {1'b0, FullKeep, stage_q};
          push_b  = 1'b1;
          entry_b = {1'b1, partial_keep, accum_q};
        end else begin
          push_a  = 1'b1;
          entry_a = {1'b1, partial_keep, accum_q};
        end
        pkt_cnt_d = pkt_cnt_q + 32'd1;
      end else if (stage_valid_q) begin
        push_a    = 1'b1;
        entry_a   = {1'b1, FullKeep, stage_q};
        pkt_cnt_d = pkt_cnt_q + 32'd1;
      end
      samp_cnt_d    = '0;
      beat_cnt_d    = '0;
      accum_d       = '0;
      stage_valid_d = 1'b0;
    end else if (accept) begin
      // Any further sample proves the staged beat was not the packet's last.
      if (stage_valid_q) begin
        push_a        = 1'b1;
        entry_a       = {1'b0, FullKeep, stage_q};
        stage_valid_d = 1'b0;
      end
      if (cnt_eff == LastLane) begin
        samp_cnt_d = '0;
        accum_d    = '0;
        if (beat_eff == LastBeat) begin
          if (push_a) begin
            push_b  = 1'b1;
            entry_b = {1'b1, FullKeep, accum_new};
          end else begin
            push_a  = 1'b1;
            entry_a = {1'b1, FullKeep, accum_new};
          end
          beat_cnt_d = '0;
          pkt_cnt_d  = pkt_cnt_q + 32'd1;
        end else begin
          stage_valid_d = 1'b1;
          stage_d       = accum_new;
          beat_cnt_d    = beat_eff + 1'b1;
        end
      end else begin
        samp_cnt_d = cnt_eff + 1'b1;
        accum_d    = accum_new;
      end
    end
  end

  // A drop in the run-start cycle must survive the clear.
  assign overflow_d = (rise ? 1'b0 : overflow_q) | fifo_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      accum_q       <= '0;
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
      overflow_q    <= 1'b0;
      pkt_cnt_q     <= '0;
    end else begin
      samp_cnt_q    <= samp_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      accum_q       <= accum_d;
      stage_valid_q <= stage_valid_d;
      stage_q       <= stage_d;
      overflow_q    <= overflow_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  axis_skid_fifo2 #(
    .Width (EntryW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_a (push_a),
    .data_a (entry_a),
    .push_b (push_b),
    .data_b (entry_b),
    .valid  (AXIS_sample_packer_AXIS_tvalid),
    .data   (fifo_head),
    .ready  (AXIS_sample_packer_AXIS_tready),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .drop   (fifo_drop)
  );

  assign AXIS_sample_packer_AXIS_tdata = fifo_head[AXIS_DATA_WIDTH-1:0];
  assign AXIS_sample_packer_AXIS_tkeep = fifo_head[AXIS_DATA_WIDTH +: AXIS_DATA_KEEP];
  assign AXIS_sample_packer_AXIS_tlast = fifo_head[EntryW-1];
  assign overflow                      = overflow_q;
  assign packet_count                  = pkt_cnt_q;

  assign unused_flags = ^{fifo_full, fifo_empty, keep_wide};

endmodule

// File: tb/tb_axis_sample_packer.sv
module tb_axis_sample_packer;

  localparam int unsigned W     = 256;
  localparam int unsigned K     = 32;
  localparam int unsigned SW    = 16;
  localparam int unsigned SPB   = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          tready = 1'b0;
  logic [W-1:0]  tdata;
  logic [K-1:0]  tkeep;
  logic          tlast, tvalid, overflow;
  logic [31:0]   packet_count;

  always #10 clk = ~clk;

  axis_sample_packer #(
    .AXIS_DATA_WIDTH (W),
    .AXIS_DATA_KEEP  (K),
    .AXIS_DATA_DEPTH (DEPTH),
    .SAMPLE_WIDTH    (SW)
  ) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .enable                         (enable),
    .sample_data                    (sample_data),
    .sample_valid                   (sample_valid),
    .AXIS_sample_packer_AXIS_tdata  (tdata),
    .AXIS_sample_packer_AXIS_tkeep  (tkeep),
    .AXIS_sample_packer_AXIS_tlast  (tlast),
    .AXIS_sample_packer_AXIS_tvalid (tvalid),
    .AXIS_sample_packer_AXIS_tready (tready),
    .overflow                       (overflow),
    .packet_count                   (packet_count)
  );

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
  } beat_t;

  beat_t exp_q[$];

  // Reference model state: samples of the open beat, beat index in packet,
  // the beat awaiting its tlast decision, and a 2-deep output queue size.
  bit            m_run;
  logic [SW-1:0] m_samples[$];
  int            m_beat;
  bit            m_stage_ok;
  logic [W-1:0]  m_stage;
  int unsigned   m_pkt;
  bit            m_ovf;
  int            m_occ;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [K-1:0] keep_for(input int n);
    logic [K-1:0] kk = '0;
    for (int b = 0; b < n * (SW / 8); b++) kk[5'(b)] = 1'b1;
    return kk;
  endfunction

  function automatic logic [W-1:0] pack_samples();
    logic [W-1:0] v = '0;
    for (int k = 0; k < m_samples.size(); k++) v[8'(k * SW) +: SW] = m_samples[k];
    return v;
  endfunction

  function automatic beat_t mk(input logic [W-1:0] d, input logic [K-1:0] kp, input logic l);
    beat_t b;
    b.data = d;
    b.keep = kp;
    b.last = l;
    return b;
  endfunction

  function automatic void model_reset();
    m_run = 0;
    m_samples.delete();
    m_beat = 0;
    m_stage_ok = 0;
    m_stage = '0;
    m_pkt = 0;
    m_ovf = 0;
    m_occ = 0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input bit en, input bit sv, input logic [SW-1:0] d,
                                     input bit rdy);
    beat_t pushes[$];
    bit rise;
    bit fall;
    rise = en && !m_run;
    fall = !en && m_run;
    if (rise) begin
      m_ovf = 0;
      m_samples.delete();
      m_beat = 0;
    end
    if (fall) begin
      if (m_samples.size() > 0) begin
        if (m_stage_ok) pushes.push_back(mk(m_stage, '1, 1'b0));
        pushes.push_back(mk(pack_samples(), keep_for(m_samples.size()), 1'b1));
        m_pkt++;
      end else if (m_stage_ok) begin
        pushes.push_back(mk(m_stage, '1, 1'b1));
        m_pkt++;
      end
      m_samples.delete();
      m_stage_ok = 0;
      m_beat = 0;
    end else if (en && sv) begin
      if (m_stage_ok) begin
        pushes.push_back(mk(m_stage, '1, 1'b0));
        m_stage_ok = 0;
      end
      m_samples.push_back(d);
      if (m_samples.size() == SPB) begin
        if (m_beat == DEPTH - 1) begin
          pushes.push_back(mk(pack_samples(), '1, 1'b1));
          m_pkt++;
          m_beat = 0;
        end else begin
          m_stage = pack_samples();
          m_stage_ok = 1;
          m_beat++;
        end
        m_samples.delete();
      end
    end
    m_run = en;
    if (m_occ > 0 && rdy) m_occ--;
    foreach (pushes[i]) begin
      if (m_occ < 2) begin
        m_occ++;
        exp_q.push_back(pushes[i]);
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  task automatic cycle(input bit en, input bit sv, input logic [SW-1:0] d, input bit rdy);
    @(posedge clk);
    #1;
    enable = en;
    sample_valid = sv;
    sample_data = d;
    tready = rdy;
    model_step(en, sv, d, rdy);
  endtask

  // Monitor: pops the scoreboard on every handshake, and checks the head
  // stays put while stalled.
  bit           stall_seen = 0;
  logic [W-1:0] held_data;
  logic         held_last;
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_seen = 0;
      end else begin
        if (stall_seen && tvalid) begin
          check("stall_tdata", tdata, held_data);
          check("stall_tlast", W'(tlast), W'(held_last));
        end
        stall_seen = tvalid && !tready;
        held_data = tdata;
        held_last = tlast;
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got tdata %h with no beat expected", tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_tdata", tdata, e.data);
            check("beat_tkeep", W'(tkeep), W'(e.keep));
            check("beat_tlast", W'(tlast), W'(e.last));
          end
        end
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, "_packet_count"}, W'(packet_count), W'(m_pkt));
    check({tag, "_overflow"}, W'(overflow), W'(m_ovf));
  endtask

  initial begin
    int rdy_pct;
    bit en;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", W'(tvalid), '0);
    check("rst_tdata", tdata, '0);
    check("rst_tkeep", W'(tkeep), '0);
    check("rst_tlast", W'(tlast), '0);
    check("rst_overflow", W'(overflow), '0);
    check("rst_packet_count", W'(packet_count), '0);
    rst_n = 1'b1;

    // Full packet of 4 beats, lane k of beat b = 16b+k.
    for (int i = 0; i < 64; i++) cycle(1, 1, SW'(i), 1);
    cycle(1, 0, '0, 1);
    check("t1_last_beat_tvalid", W'(tvalid), W'(1));
    check("t1_last_beat_tlast", W'(tlast), W'(1));
    repeat (4) cycle(1, 0, '0, 1);
    check("t1_packet_count_is_1", W'(packet_count), W'(1));
    repeat (3) cycle(0, 0, '0, 1);
    check_status("t1");

    // 20 samples then stop: a full beat and a 4-sample partial beat.
    for (int i = 0; i < 20; i++) cycle(1, 1, SW'($urandom), 1);
    cycle(0, 1, SW'($urandom), 1);
    repeat (4) cycle(0, 0, '0, 1);
    check("t2_packet_count_is_2", W'(packet_count), W'(2));
    check_status("t2");

    // 32 samples then stop: the staged second beat closes the packet.
    for (int i = 0; i < 32; i++) cycle(1, 1, SW'($urandom), 1);
    cycle(0, 0, '0, 1);
    repeat (4) cycle(0, 0, '0, 1);
    check("t3_packet_count_is_3", W'(packet_count), W'(3));
    check_status("t3");

    // Sink stalled: third and fourth pushes are lost.
    for (int i = 0; i < 64; i++) cycle(1, 1, SW'($urandom), 0);
    repeat (2) cycle(1, 0, '0, 0);
    check("t4_overflow_set", W'(overflow), W'(1));
    check("t4_tvalid_held", W'(tvalid), W'(1));
    check_status("t4a");
    repeat (6) cycle(1, 0, '0, 1);
    repeat (3) cycle(0, 0, '0, 1);
    check("t4_overflow_sticky_idle", W'(overflow), W'(1));
    repeat (2) cycle(1, 0, '0, 1);
    check("t4_overflow_cleared", W'(overflow), '0);
    repeat (3) cycle(0, 0, '0, 1);
    check_status("t4b");

    // Ready toggling each cycle with a sample every cycle.
    for (int i = 0; i < 80; i++) cycle(1, 1, SW'($urandom), i % 2 == 0);
    cycle(0, 0, '0, 0);
    repeat (6) cycle(0, 0, '0, 1);
    check("t5_no_overflow", W'(overflow), '0);
    check_status("t5");

    // Randomised traffic with varying sink throughput.
    en = 0;
    for (int blk = 0; blk < 6; blk++) begin
      rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 60 : 100);
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 99) < 3) en = !en;
        cycle(en, $urandom_range(0, 3) != 0, SW'($urandom), $urandom_range(0, 99) < rdy_pct);
      end
      check_status("rand_blk");
    end
    cycle(0, 0, '0, 1);
    repeat (6) cycle(0, 0, '0, 1);
    check_status("rand_end");

    // Asynchronous reset in the middle of a packet.
    for (int i = 0; i < 23; i++) cycle(1, 1, SW'($urandom), 0);
    check("mid_pre_reset_tvalid", W'(tvalid), W'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    enable = 1'b0;
    sample_valid = 1'b0;
    #1;
    check("mid_reset_tvalid", W'(tvalid), '0);
    check("mid_reset_packet_count", W'(packet_count), '0);
    check("mid_reset_tdata", tdata, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) cycle(1, 1, SW'(i + 1000), 1);
    repeat (4) cycle(1, 0, '0, 1);
    repeat (4) cycle(0, 0, '0, 1);
    check("mid_packet_count_is_1", W'(packet_count), W'(1));
    check_status("mid");

    check("scoreboard_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
